regfile_wb_arbiter: RTL and testbench

Write-side initiator for the 32x32 register file. It merges two writeback sources onto the file's single write port (`we`/`rd`/`wd`): load responses, which are never stalled, and ALU results, which are buffered in a small FIFO. It also forwards pending, not-yet-committed values to the decode stage's `rs1`/`rs2` lookups, so operand reads stay correct while writes are queued.

---
 rtl/regfile_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Merges never-stalled load writebacks and FIFO-buffered ALU writebacks onto
// the single register-file write port. Pending, uncommitted values are
// forwarded to two decode-stage lookup ports.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_wd,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_rd,
  input  logic [31:0]              ld_wd,
  output logic                     we,
  output logic [4:0]               rd,
  output logic [31:0]              wd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     fwd1_hit,
  output logic [31:0]              fwd1_data,
  output logic                     fwd2_hit,
  output logic [31:0]              fwd2_data,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       ent_rd [DEPTH];
  logic [31:0]      ent_wd [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic ld_eff;
  logic fifo_empty;
  logic alu_keep;
  logic push;
  logic pop;
  logic direct;

  // Readiness comes from occupancy alone, so a popping cycle never frees a full FIFO early.
  assign alu_ready  = (count != CW'(DEPTH));
  assign pending    = count;
  assign fifo_empty = (count == '0);
  // Loads to x0 are discarded and do not occupy the port.
  assign ld_eff     = ld_valid && (ld_rd != 5'd0);
  // ALU requests to x0 are accepted but dropped.
  assign alu_keep   = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign push       = alu_keep && (ld_eff || !fifo_empty);
  assign pop        = !ld_eff && !fifo_empty;
  assign direct     = alu_keep && !ld_eff && fifo_empty;

  // Output stage: load beats FIFO head beats direct ALU; idle cycles hold rd/wd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we <= 1'b0;
      rd <= 5'd0;
      wd <= 32'd0;
    end else if (ld_eff) begin
      we <= 1'b1;
      rd <= ld_rd;
      wd <= ld_wd;
    end else if (pop) begin
      // An invalidated head still consumes this cycle, with no write.
      we <= ent_vld[head];
      if (ent_vld[head]) begin
        rd <= ent_rd[head];
        wd <= ent_wd[head];
      end
    end else if (direct) begin
      we <= 1'b1;
      rd <= alu_rd;
      wd <= alu_wd;
    end else begin
      we <= 1'b0;
    end
  end

  // FIFO control: pointers, occupancy and per-entry valid bits (load kills older same-rd entries).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ld_eff && ent_vld[j] && (ent_rd[j] == ld_rd)) begin
          ent_vld[j] <= 1'b0;
        end
      end
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // FIFO payload storage; needs no reset since valid bits and occupancy guard it.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[tail] <= alu_rd;
      ent_wd[tail] <= alu_wd;
    end
  end

  logic [PW-1:0] fidx;

  // Forwarding: output register is the oldest candidate, then FIFO head to tail; last match wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = 32'd0;
    fwd2_hit  = 1'b0;
    fwd2_data = 32'd0;
    fidx      = '0;
    if (we && (rd == rs1) && (rs1 != 5'd0)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = wd;
    end
    if (we && (rd == rs2) && (rs2 != 5'd0)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = wd;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fidx = head + PW'(i);
      if ((CW'(i) < count) && ent_vld[fidx]) begin
        if ((ent_rd[fidx] == rs1) && (rs1 != 5'd0)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = ent_wd[fidx];
        end
        if ((ent_rd[fidx] == rs2) && (rs2 != 5'd0)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = ent_wd[fidx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (DEPTH = 4).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_wd;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [2:0]  pending;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_wd    (alu_wd),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_wd     (ld_wd),
    .we        (we),
    .rd        (rd),
    .wd        (wd),
    .rs1       (rs1),
    .rs2       (rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    alu_rd    = 5'd0;
    alu_wd    = 32'd0;
    ld_valid  = 1'b0;
    ld_rd     = 5'd0;
    ld_wd     = 32'd0;
  endtask

  // The port must never write x0.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_chk++;
      assert (!(we === 1'b1 && rd === 5'd0)) else begin
        n_fail++;
        $error("FAIL we_rd0 observed we=%0b rd=%0d expected no write to x0", we, rd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rs1   = 5'd0;
    rs2   = 5'd0;
    rst_n = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_wd    = 32'h99;

    // Reset held two edges with an ALU request present
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ready", 32'(alu_ready), 32'd1);

    // Uncontended ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'h11;
    tick();
    idle();
    chk("unc_we", 32'(we), 32'd1);
    chk("unc_rd", 32'(rd), 32'd5);
    chk("unc_wd", wd, 32'h11);
    chk("unc_pending", 32'(pending), 32'd0);
    rs1 = 5'd5;
    #1;
    chk("unc_fwd_hit", 32'(fwd1_hit), 32'd1);
    chk("unc_fwd_data", fwd1_data, 32'h11);
    tick();
    chk("unc_we_after", 32'(we), 32'd0);
    chk("unc_rd_hold", 32'(rd), 32'd5);
    chk("unc_fwd_hit_after", 32'(fwd1_hit), 32'd0);
    chk("unc_fwd_data_after", fwd1_data, 32'd0);

    // Contention and fill: load to rd=20 held six cycles, ALU pushes rd=1..6
    for (int c = 0; c < 6; c++) begin
      ld_valid = 1'b1; ld_rd = 5'd20; ld_wd = 32'(32'h200 + c);
      alu_valid = 1'b1; alu_rd = 5'(c + 1); alu_wd = 32'(32'h31 + c);
      tick();
      chk("fill_we", 32'(we), 32'd1);
      chk("fill_rd", 32'(rd), 32'd20);
      chk("fill_wd", wd, 32'(32'h200 + c));
      chk("fill_pending", 32'(pending), (c < 3) ? 32'(c + 1) : 32'd4);
      chk("fill_ready", 32'(alu_ready), (c < 3) ? 32'd1 : 32'd0);
    end
    idle();
    rs1 = 5'd2; rs2 = 5'd20;
    #1;
    chk("full_fwd1_hit", 32'(fwd1_hit), 32'd1);
    chk("full_fwd1_data", fwd1_data, 32'h32);
    chk("full_fwd2_hit", 32'(fwd2_hit), 32'd1);
    chk("full_fwd2_data", fwd2_data, 32'h205);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_we", 32'(we), 32'd1);
      chk("drain_rd", 32'(rd), 32'(k + 1));
      chk("drain_wd", wd, 32'(32'h31 + k));
      chk("drain_pending", 32'(pending), 32'(3 - k));
    end
    tick();
    chk("drain_done_we", 32'(we), 32'd0);
    chk("drain_done_ready", 32'(alu_ready), 32'd1);

    // Invalidate: queue ALU rd=7 behind load rd=9, then load rd=7
    ld_valid = 1'b1; ld_rd = 5'd9; ld_wd = 32'h90;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'hA;
    tick();
    idle();
    chk("inv_q_pending", 32'(pending), 32'd1);
    chk("inv_q_rd", 32'(rd), 32'd9);
    rs2 = 5'd7;
    #1;
    chk("inv_q_fwd_data", fwd2_data, 32'hA);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_wd = 32'hB;
    tick();
    idle();
    chk("inv_ld_we", 32'(we), 32'd1);
    chk("inv_ld_rd", 32'(rd), 32'd7);
    chk("inv_ld_wd", wd, 32'hB);
    chk("inv_ld_pending", 32'(pending), 32'd1);
    chk("inv_ld_fwd_hit", 32'(fwd2_hit), 32'd1);
    chk("inv_ld_fwd_data", fwd2_data, 32'hB);
    tick();
    chk("inv_pop_we", 32'(we), 32'd0);
    chk("inv_pop_pending", 32'(pending), 32'd0);
    chk("inv_pop_wd_hold", wd, 32'hB);
    chk("inv_pop_fwd_hit", 32'(fwd2_hit), 32'd0);
    chk("inv_pop_fwd_data", fwd2_data, 32'd0);

    // Youngest-first forwarding: two rd=3 entries behind loads to rd=9
    ld_valid = 1'b1; ld_rd = 5'd9; ld_wd = 32'h91;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'd1;
    tick();
    ld_wd = 32'h92; alu_wd = 32'd2;
    tick();
    idle();
    rs1 = 5'd3; rs2 = 5'd9;
    #1;
    chk("yf_pending", 32'(pending), 32'd2);
    chk("yf_fwd1_hit", 32'(fwd1_hit), 32'd1);
    chk("yf_fwd1_data", fwd1_data, 32'd2);
    chk("yf_fwd2_data", fwd2_data, 32'h92);
    tick();
    chk("yf_pop1_wd", wd, 32'd1);
    chk("yf_pop1_fwd1_data", fwd1_data, 32'd2);
    tick();
    chk("yf_pop2_wd", wd, 32'd2);
    chk("yf_pop2_pending", 32'(pending), 32'd0);
    tick();
    chk("yf_idle_we", 32'(we), 32'd0);

    // x0 filtering: queue rd=4, then ALU rd=0 and load rd=0 together
    ld_valid = 1'b1; ld_rd = 5'd9; ld_wd = 32'h93;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'h44;
    tick();
    chk("x0_q_pending", 32'(pending), 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd0; ld_wd = 32'h55;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hFFFF;
    tick();
    idle();
    chk("x0_we", 32'(we), 32'd1);
    chk("x0_rd", 32'(rd), 32'd4);
    chk("x0_wd", wd, 32'h44);
    chk("x0_pending", 32'(pending), 32'd0);
    tick();
    chk("x0_idle_we", 32'(we), 32'd0);
    // Load to x0 yields the port to a direct ALU write
    ld_valid = 1'b1; ld_rd = 5'd0; ld_wd = 32'h77;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_wd = 32'h66;
    tick();
    idle();
    chk("x0_direct_we", 32'(we), 32'd1);
    chk("x0_direct_rd", 32'(rd), 32'd6);
    chk("x0_direct_wd", wd, 32'h66);
    chk("x0_direct_pending", 32'(pending), 32'd0);
    // Lone ALU request to x0 is accepted and dropped
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'h1234;
    tick();
    idle();
    chk("x0_alu_we", 32'(we), 32'd0);
    chk("x0_alu_pending", 32'(pending), 32'd0);

    // Reset mid-operation drops queued writes
    ld_valid = 1'b1; ld_rd = 5'd9; ld_wd = 32'h94;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_wd = 32'h88;
    tick();
    idle();
    chk("mrst_q_pending", 32'(pending), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_we", 32'(we), 32'd0);
    chk("mrst_pending", 32'(pending), 32'd0);
    chk("mrst_ready", 32'(alu_ready), 32'd1);
    tick();
    chk("mrst_no_commit", 32'(we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
